// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and helpers used by the memory-mapped masters.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AxSIZE encoding for a bus of dw bits (8..1024)
  function automatic logic [2:0] axsize_from_width(input int unsigned dw);
    logic [2:0] r_size;
    r_size = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd8 << i) == dw) r_size = 3'(i);
    end
    return r_size;
  endfunction

endpackage

// File: rtl/axis_to_aximm.sv
// Streams AXIS beats into consecutive fixed-length AXI4 INCR write bursts,
// keeping at most MAX_OUTSTANDING address phases ahead of their responses.
module axis_to_aximm
  import axi_pkg::*;
#(
  parameter int unsigned DW              = 512,
  parameter int unsigned AW              = 64,
  parameter int unsigned BURST_BEATS     = 64,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [31:0]       burst_count,
  output logic              busy,
  output logic              done,
  output logic              bresp_err,

  input  logic [DW-1:0]     AXIS_IN_TDATA,
  input  logic [DW/8-1:0]   AXIS_IN_TKEEP,
  input  logic              AXIS_IN_TVALID,
  output logic              AXIS_IN_TREADY,

  output logic [AW-1:0]     M_AXI_AWADDR,
  output logic [7:0]        M_AXI_AWLEN,
  output logic [2:0]        M_AXI_AWSIZE,
  output logic [1:0]        M_AXI_AWBURST,
  output logic [3:0]        M_AXI_AWID,
  output logic              M_AXI_AWLOCK,
  output logic [3:0]        M_AXI_AWCACHE,
  output logic [2:0]        M_AXI_AWPROT,
  output logic [3:0]        M_AXI_AWQOS,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,

  output logic [DW-1:0]     M_AXI_WDATA,
  output logic [DW/8-1:0]   M_AXI_WSTRB,
  output logic              M_AXI_WLAST,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,

  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY
);

  localparam int unsigned CW          = 32;
  localparam int unsigned BEAT_W      = 8;
  localparam int unsigned BURST_BYTES = BURST_BEATS * DW / 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_bresp_err;
  logic [AW-1:0]     r_base;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_aw_cnt;
  logic [CW-1:0]     r_w_cnt;
  logic [CW-1:0]     r_b_cnt;
  logic [BEAT_W-1:0] r_beat;

  logic              w_run;
  logic              w_start;
  logic              w_en;
  logic              w_last;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_b_final;
  logic [CW-1:0]     w_outstanding;

  assign w_run         = (r_state == S_RUN);
  assign w_start       = (r_state == S_IDLE) && start;
  assign w_outstanding = r_aw_cnt - r_b_cnt;
  assign w_last        = (r_beat == BEAT_W'(BURST_BEATS - 1));
  // W may only run for bursts whose address phase has already completed
  assign w_en          = w_run && (r_w_cnt < r_aw_cnt);

  assign w_aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs    = M_AXI_WVALID && M_AXI_WREADY;
  assign w_b_hs    = M_AXI_BVALID && M_AXI_BREADY;
  assign w_b_final = w_b_hs && (CW'(r_b_cnt + 32'd1) == r_count);

  assign M_AXI_AWVALID = w_run && (r_aw_cnt < r_count) &&
                         (w_outstanding < CW'(MAX_OUTSTANDING));
  assign M_AXI_AWADDR  = r_base + AW'(r_aw_cnt) * AW'(BURST_BYTES);
  assign M_AXI_AWLEN   = 8'(BURST_BEATS - 1);
  assign M_AXI_AWSIZE  = axsize_from_width(DW);
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWID    = 4'd0;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'd0;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWQOS   = 4'd0;

  assign M_AXI_WDATA    = AXIS_IN_TDATA;
  assign M_AXI_WSTRB    = AXIS_IN_TKEEP;
  assign M_AXI_WLAST    = w_last;
  assign M_AXI_WVALID   = AXIS_IN_TVALID && w_en;
  assign AXIS_IN_TREADY = M_AXI_WREADY && w_en;

  assign M_AXI_BREADY = w_run;
  assign busy         = w_run;
  assign done         = r_done;
  assign bresp_err    = r_bresp_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Zero-length requests complete without ever leaving IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (burst_count == 32'd0) w_done_nxt  = 1'b1;
          else                      w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_b_final) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Each channel advances on its own handshake; all may fire in one cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_base      <= '0;
      r_count     <= '0;
      r_aw_cnt    <= '0;
      r_w_cnt     <= '0;
      r_b_cnt     <= '0;
      r_beat      <= '0;
      r_bresp_err <= 1'b0;
    end else if (w_start) begin
      r_base      <= base_addr;
      r_count     <= burst_count;
      r_aw_cnt    <= '0;
      r_w_cnt     <= '0;
      r_b_cnt     <= '0;
      r_beat      <= '0;
      r_bresp_err <= 1'b0;
    end else if (w_run) begin
      if (w_aw_hs) r_aw_cnt <= r_aw_cnt + 32'd1;
      if (w_w_hs) begin
        if (w_last) begin
          r_w_cnt <= r_w_cnt + 32'd1;
          r_beat  <= '0;
        end else begin
          r_beat  <= r_beat + 8'd1;
        end
      end
      if (w_b_hs) begin
        r_b_cnt <= r_b_cnt + 32'd1;
        if (M_AXI_BRESP != RESP_OKAY) r_bresp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_to_aximm.sv
// Scoreboard bench for axis_to_aximm: expected AW/W traffic is queued when a
// transfer is issued and a negedge monitor checks every handshake against it.
module tb_axis_to_aximm;

  localparam int unsigned DW  = 512;
  localparam int unsigned AW  = 64;
  localparam int unsigned BB  = 4;
  localparam int unsigned MO  = 2;
  localparam int unsigned KW  = DW / 8;
  localparam logic [63:0] BURST_BYTES = 64'd256;

  logic            clk = 1'b0;
  logic            resetn;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [31:0]     burst_count;
  logic            busy, done, bresp_err;
  logic [DW-1:0]   tdata;
  logic [KW-1:0]   tkeep;
  logic            tvalid, tready;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [3:0]      awid, awcache, awqos;
  logic            awlock;
  logic [2:0]      awprot;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [KW-1:0]   wstrb;
  logic            wlast, wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;

  axis_to_aximm #(.DW(DW), .AW(AW), .BURST_BEATS(BB), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .burst_count(burst_count), .busy(busy), .done(done), .bresp_err(bresp_err),
    .AXIS_IN_TDATA(tdata), .AXIS_IN_TKEEP(tkeep), .AXIS_IN_TVALID(tvalid),
    .AXIS_IN_TREADY(tready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWID(awid), .M_AXI_AWLOCK(awlock),
    .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } wexp_t;

  logic [AW-1:0] exp_aw[$];
  wexp_t         exp_w[$];

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus knobs owned by the test sequence
  int src_total = 0;
  int tv_rate = 100, wr_rate = 100, aw_rate = 100, b_rate = 100;
  int b_en = 1;
  int err_idx = -1;

  // driver-owned state
  int src_idx = 0;
  int wlast_drv = 0;
  int b_issued = 0;

  // monitor-owned state
  int aw_inflight = 0, wl_cnt = 0, aw_hs_total = 0, w_beat_total = 0, done_cnt = 0;
  logic          prev_stall = 1'b0, prev_done = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  function automatic logic [DW-1:0] data_of(input int k);
    return {16{32'hA500_0000 + 32'(k)}};
  endfunction

  function automatic logic [KW-1:0] keep_of(input int k);
    return {8{8'hFF ^ 8'(k)}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Source, sink-ready and B responder
  always begin : driver
    logic t_hs, wl_hs, b_hs, rst;
    @(negedge clk);
    t_hs  = tvalid && tready;
    wl_hs = wvalid && wready && wlast;
    b_hs  = bvalid && bready;
    rst   = !resetn;
    @(posedge clk);
    #1;
    if (rst) begin
      wlast_drv = 0;
      b_issued  = 0;
      bvalid    = 1'b0;
    end else begin
      if (t_hs) src_idx++;
      if (wl_hs) wlast_drv++;
      if (b_hs) begin
        b_issued++;
        bvalid = 1'b0;
      end
    end
    tvalid  = (src_idx < src_total) && (int'($urandom % 100) < tv_rate);
    tdata   = data_of(src_idx);
    tkeep   = keep_of(src_idx);
    wready  = int'($urandom % 100) < wr_rate;
    awready = int'($urandom % 100) < aw_rate;
    if (!bvalid && (b_en != 0) && (wlast_drv > b_issued) && (int'($urandom % 100) < b_rate)) begin
      bvalid = 1'b1;
      bresp  = (b_issued == err_idx) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: pops expectations at every handshake
  always @(negedge clk) begin
    wexp_t e;
    if (!resetn) begin
      aw_inflight = 0;
      wl_cnt      = 0;
      prev_stall  = 1'b0;
      prev_done   = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("awvalid_stable", DW'(awvalid), DW'(1'b1));
        chk("awaddr_stable", DW'(awaddr), DW'(prev_addr));
      end
      if (wvalid && wready) begin
        chk("w_after_aw", DW'(wl_cnt < aw_inflight), DW'(1'b1));
        if (exp_w.size() == 0) fail_now("w_extra", 1, 0);
        else begin
          e = exp_w.pop_front();
          chk("wdata", wdata, e.d);
          chk("wstrb", DW'(wstrb), DW'(e.k));
          chk("wlast", DW'(wlast), DW'(e.l));
        end
        w_beat_total++;
        if (wlast) wl_cnt++;
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) fail_now("aw_extra", 1, 0);
        else chk("awaddr", DW'(awaddr), DW'(exp_aw.pop_front()));
        chk("aw_fixed", DW'({awlen, awsize, awburst, awid, awlock, awcache, awprot, awqos}),
            DW'({8'd3, 3'd6, 2'b01, 4'd0, 1'b0, 4'd0, 3'd0, 4'd0}));
        aw_inflight++;
        aw_hs_total++;
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", DW'(busy), DW'(1'b0));
        chk("done_single", DW'(prev_done), DW'(1'b0));
        chk("queues_drained_at_done", DW'(exp_aw.size() + exp_w.size()), DW'(0));
      end
      prev_done  = done;
      prev_stall = awvalid && !awready;
      prev_addr  = awaddr;
    end
  end

  task automatic issue(input logic [AW-1:0] base, input int cnt);
    int s0;
    s0 = src_idx;
    for (int b = 0; b < cnt; b++) exp_aw.push_back(base + AW'(b) * BURST_BYTES);
    for (int j = 0; j < cnt * int'(BB); j++)
      exp_w.push_back('{d: data_of(s0 + j), k: keep_of(s0 + j), l: ((j % int'(BB)) == int'(BB) - 1)});
    src_total   = s0 + cnt * int'(BB);
    base_addr   = base;
    burst_count = 32'(cnt);
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int b0;
    bit seen;
    b0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done_cnt > b0) seen = 1'b1;
    end
    if (!seen) fail_now({nm, "_timeout"}, done_cnt, b0 + 1);
    repeat (3) step();
    chk({nm, "_done_once"}, DW'(done_cnt), DW'(b0 + 1));
  endtask

  task automatic set_rates(input int r);
    tv_rate = r; wr_rate = r; aw_rate = r; b_rate = r;
  endtask

  task automatic chk_reset_outputs(input string nm);
    @(negedge clk);
    chk(nm, DW'({busy, done, bresp_err, awvalid, wvalid, tready, bready}), DW'(7'b0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : test
    int aw0, wb0;
    resetn = 1'b0; start = 1'b0; base_addr = '0; burst_count = '0;
    tvalid = 1'b0; tdata = '0; tkeep = '0; wready = 1'b0; awready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00;
    repeat (3) step();
    chk_reset_outputs("reset_outputs");
    step();
    resetn = 1'b1;
    step();

    // basic transfer, all ready
    set_rates(100);
    issue(64'h1000, 3);
    wait_done("basic", 200);

    // outstanding limit with B withheld
    b_en = 0;
    aw0 = aw_hs_total;
    wb0 = w_beat_total;
    issue(64'h10000, 4);
    repeat (40) step();
    chk("outst_aw_count", DW'(aw_hs_total - aw0), DW'(2));
    chk("outst_w_count", DW'(w_beat_total - wb0), DW'(8));
    @(negedge clk);
    chk("outst_tready_low", DW'(tready), DW'(1'b0));
    chk("outst_busy", DW'(busy), DW'(1'b1));
    b_en = 1;
    wait_done("outst", 200);

    // error response on the second burst
    err_idx = b_issued + 1;
    issue(64'h20000, 3);
    wait_done("err", 200);
    chk("bresp_err_sticky", DW'(bresp_err), DW'(1'b1));
    err_idx = -1;

    // random stalls; a second start while busy must be ignored
    set_rates(60);
    issue(64'h4_0000, 5);
    @(negedge clk);
    chk("bresp_err_cleared", DW'(bresp_err), DW'(1'b0));
    repeat (4) step();
    chk("busy_during_run", DW'(busy), DW'(1'b1));
    base_addr   = 64'hDEAD_0000;
    burst_count = 32'd1;
    start       = 1'b1;
    step();
    start       = 1'b0;
    wait_done("random", 2000);

    // address wraps modulo 2^AW
    set_rates(75);
    issue(64'hFFFF_FFFF_FFFF_FF00, 2);
    wait_done("wrap", 1000);

    // zero count completes from IDLE on the next cycle
    set_rates(100);
    base_addr   = 64'h5000;
    burst_count = 32'd0;
    start       = 1'b1;
    @(negedge clk);
    chk("zero_done_early", DW'(done), DW'(1'b0));
    step();
    start = 1'b0;
    @(negedge clk);
    chk("zero_done_pulse", DW'({done, busy}), DW'(2'b10));
    @(negedge clk);
    chk("zero_done_end", DW'({done, busy}), DW'(2'b00));
    step();

    // reset during beat 2 of burst 1, then restart at a new base
    aw0 = src_idx;
    issue(64'h8000, 3);
    for (int i = 0; i < 50 && src_idx < aw0 + 1; i++) step();
    chk("rst_reached_beat2", DW'(src_idx), DW'(aw0 + 1));
    resetn = 1'b0;
    step();
    chk_reset_outputs("midrun_reset_outputs");
    exp_aw.delete();
    exp_w.delete();
    src_total = src_idx;
    step();
    resetn = 1'b1;
    step();
    chk_reset_outputs("post_reset_idle");
    issue(64'hC000, 2);
    wait_done("restart", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_to_aximm.md
AXIS_TO_AXIMM -- requirements
Module: axis_to_aximm

Interface
REQ-001 SHALL have parameters: DW, default 512, data width (bits); AW, default 64, address width; BURST_BEATS, default 64, beats per burst (1..256, BURST_BEATS*DW/8 <= 4096); MAX_OUTSTANDING, default 8, maximum AWs issued but not yet B-acknowledged (1..255).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- resetn  in  1  reset: synchronous, active-low
- start  in  1  begin transfer; sampled only in IDLE
- base_addr  in  AW  first burst address; caller aligns it to BURST_BYTES
- burst_count  in  32  number of bursts to write
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- bresp_err  out  1  sticky; set by any non-OKAY BRESP
- AXIS_IN_TDATA / TKEEP / TVALID / TREADY  in/in/in/out  DW/DW/8/1/1  input stream; TLAST is not used
- M_AXI_AWADDR / AWLEN / AWSIZE / AWBURST / AWID / AWLOCK / AWCACHE / AWPROT / AWQOS  out  AW/8/3/2/4/1/4/3/4  write address
- M_AXI_AWVALID / AWREADY  out/in  1/1
- M_AXI_WDATA / WSTRB / WLAST / WVALID  out  DW/DW/8/1/1
- M_AXI_WREADY  in  1
- M_AXI_BRESP / BVALID  in  2/1
- M_AXI_BREADY  out  1
- The block is write-only and has no read-channel ports.

Function
REQ-003 SHALL define BURST_BYTES = BURST_BEATS*DW/8 and implement FSM states IDLE and RUN.
REQ-004 SHALL act on start in IDLE as follows: latch base_addr and burst_count, clear aw_cnt, w_cnt, b_cnt, beat counter and bresp_err, then enter RUN; if burst_count==0, stay in IDLE and pulse done on the next cycle.
REQ-005 SHALL ignore start while in RUN.
REQ-006 SHALL drive AWVALID = RUN & (aw_cnt < burst_count) & ((aw_cnt - b_cnt) < MAX_OUTSTANDING).
REQ-007 SHALL drive AWADDR = base + aw_cnt*BURST_BYTES, modulo 2^AW.
REQ-008 SHALL hold AWADDR and AWVALID stable until the AWREADY handshake.
REQ-009 SHALL increment aw_cnt on each AW handshake.
REQ-010 SHALL drive constant AW fields: AWLEN = BURST_BEATS-1; AWSIZE = log2(DW/8); AWBURST = INCR (2'b01); AWID, AWLOCK, AWCACHE, AWPROT and AWQOS = 0.
REQ-011 SHALL pass W data through combinationally: WDATA = TDATA, WSTRB = TKEEP.
REQ-012 SHALL gate the W channel with w_en = RUN & (w_cnt < aw_cnt), so W data of burst n never precedes its AW handshake: WVALID = TVALID & w_en; TREADY = WREADY & w_en.
REQ-013 SHALL count W beats 0..BURST_BEATS-1 and assert WLAST on the last beat; when BURST_BEATS=1, WLAST SHALL be asserted on every beat.
REQ-014 SHALL, on a W handshake with WLAST, increment w_cnt and clear the beat counter.
REQ-015 SHALL drive BREADY = 1 in RUN and 0 in IDLE.
REQ-016 SHALL increment b_cnt on each B handshake and set bresp_err when BRESP != 2'b00.
REQ-017 SHALL transition RUN -> IDLE when a B handshake makes b_cnt == burst_count, asserting done for exactly one cycle.
REQ-018 SHALL update counters independently, so simultaneous AW, W-last and B handshakes in one cycle each take effect.
REQ-019 SHALL use 32-bit counters; burst_count up to 2^32-1 SHALL complete correctly.

Reset
REQ-020 SHALL, when resetn==0 at a clk edge, enter IDLE, clear all counters, busy, done and bresp_err, and deassert AWVALID, WVALID, TREADY and BREADY.
REQ-021 SHALL abandon in-flight transactions on reset mid-operation, with no further AW, W or B activity until the next start.

Structure
REQ-022 SHALL take the AXI encodings (BURST_INCR, RESP_OKAY) and the AWSIZE-from-width function from the shared package axi_pkg.
REQ-023 SHALL be implemented as a single module with no sub-modules.

Verification
REQ-024 Basic transfer (DW=512, BURST_BEATS=4, MAX_OUTSTANDING=2, base 0x1000, count 3, all ready): AWADDR 0x1000, 0x1100, 0x1200; AWLEN=3; AWSIZE=6; WLAST on beats 4, 8, 12; done pulses once after the 3rd B; busy falls the same cycle.
REQ-025 Outstanding limit (count 4, BVALID withheld): exactly 2 AW handshakes and 8 W beats, then TREADY=0; releasing B lets bursts 3-4 proceed.
REQ-026 Error response (BRESP=2'b10 on burst 2 of 3): bresp_err=1 from that cycle, transfer still completes with done, bresp_err cleared by the next start.
REQ-027 Zero count (start with burst_count=0): no AWVALID, done pulses one cycle later, busy stays 0.
REQ-028 Reset and restart: resetn low during beat 2 of burst 1 returns all outputs to reset values; start while busy is ignored; a fresh start after reset begins at the new base_addr.
REQ-029 Random TVALID/WREADY/AWREADY/BVALID stalls: data order preserved, no W beat precedes its AW, AWADDR/AWVALID stable while stalled.
